// File: rtl/encoder_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | encoder_sequencer_if : control/status bundle of the encoder phase sequencer |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface encoder_sequencer_if;
    logic       enable;
    logic       bx_strobe;
    logic [3:0] mux_delay;
    logic       cnt_clear;
    logic       latch0;
    logic       latch1;
    logic       mux_sel;
    logic [2:0] phase;
    logic       locked;
    logic [7:0] misalign_cnt;

    modport master (
        output enable, bx_strobe, mux_delay, cnt_clear,
        input  latch0, latch1, mux_sel, phase, locked, misalign_cnt
    );

    modport slave (
        input  enable, bx_strobe, mux_delay, cnt_clear,
        output latch0, latch1, mux_sel, phase, locked, misalign_cnt
    );
endinterface

`default_nettype wire

// File: rtl/encoder_sequencer.sv
// +----------------------------------------------------------------------------+
// | encoder_sequencer : BX-strobe phase tracker driving the even/odd encoder   |
// | latches and the delayed output-mux select.                    rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module encoder_sequencer #(
    parameter int LOCK_STROBES = 4,
    parameter int ENC_OFFSET   = 4
) (
    input  logic                clock4x,
    input  logic                global_reset,
    encoder_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEEK    = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [7:0]  misalign_cnt_q, misalign_cnt_d;
    logic [15:0] mux_sr_q, mux_sr_d;
    logic        mux_sel_q, mux_sel_d;
    logic        latch0_q, latch0_d;
    logic        latch1_q, latch1_d;
    logic        locked_q, locked_d;

    logic        w_slot;
    logic        w_tracking;
    logic        w_event;

    // A strobe is due exactly on the 0/4 phases; any disagreement is a misalignment.
    assign w_slot     = (phase_q[1:0] == 2'd0);
    assign w_tracking = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
    assign w_event    = bus.enable && w_tracking && (bus.bx_strobe != w_slot);

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        good_cnt_d     = good_cnt_q;
        misalign_cnt_d = misalign_cnt_q;

        if (!bus.enable) begin
            state_d = ST_IDLE;
            phase_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEEK;
                    phase_d = 3'd0;
                end
                ST_SEEK: begin
                    phase_d = 3'd0;
                    if (bus.bx_strobe) begin
                        state_d    = ST_ACQUIRE;
                        phase_d    = 3'd1;
                        good_cnt_d = 4'd0;
                    end
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    phase_d = phase_q + 3'd1;
                    if (bus.bx_strobe && !w_slot) begin
                        // Early/late strobe: realign straight onto it.
                        state_d    = ST_ACQUIRE;
                        phase_d    = 3'd1;
                        good_cnt_d = 4'd0;
                    end else if (!bus.bx_strobe && w_slot) begin
                        state_d = ST_SEEK;
                        phase_d = 3'd0;
                    end else if (bus.bx_strobe && (state_q == ST_ACQUIRE)) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_d == 4'(LOCK_STROBES)) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = 3'd0;
                end
            endcase
        end

        if (bus.cnt_clear) begin
            misalign_cnt_d = 8'd0;
        end else if (w_event && (misalign_cnt_q != 8'hFF)) begin
            misalign_cnt_d = misalign_cnt_q + 8'd1;
        end
    end

    assign latch0_d  = bus.enable && (state_q == ST_LOCKED) && (phase_q == 3'd0);
    assign latch1_d  = bus.enable && (state_q == ST_LOCKED) && (phase_q == 3'(ENC_OFFSET));
    assign locked_d  = (state_d == ST_LOCKED);
    assign mux_sr_d  = {mux_sr_q[14:0], phase_q[2]};
    assign mux_sel_d = mux_sr_q[bus.mux_delay];

    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            state_q        <= ST_IDLE;
            phase_q        <= 3'd0;
            good_cnt_q     <= 4'd0;
            misalign_cnt_q <= 8'd0;
            mux_sr_q       <= 16'd0;
            mux_sel_q      <= 1'b0;
            latch0_q       <= 1'b0;
            latch1_q       <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            good_cnt_q     <= good_cnt_d;
            misalign_cnt_q <= misalign_cnt_d;
            mux_sr_q       <= mux_sr_d;
            mux_sel_q      <= mux_sel_d;
            latch0_q       <= latch0_d;
            latch1_q       <= latch1_d;
            locked_q       <= locked_d;
        end
    end

    assign bus.latch0       = latch0_q;
    assign bus.latch1       = latch1_q;
    assign bus.mux_sel      = mux_sel_q;
    assign bus.phase        = phase_q;
    assign bus.locked       = locked_q;
    assign bus.misalign_cnt = misalign_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_encoder_sequencer : directed scoreboard bench for encoder_sequencer     |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_encoder_sequencer;

    typedef struct {
        int kind;   // 0 latch0, 1 latch1, 2 locked rise, 3 locked fall
        int at;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_locked = 1'b0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    encoder_sequencer_if bus();

    encoder_sequencer #(
        .LOCK_STROBES (4),
        .ENC_OFFSET   (4)
    ) dut (
        .clock4x      (clk),
        .global_reset (rst),
        .bus          (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs(input string name);
        check({name, "_latch0"},   int'(bus.latch0),       0);
        check({name, "_latch1"},   int'(bus.latch1),       0);
        check({name, "_mux_sel"},  int'(bus.mux_sel),      0);
        check({name, "_phase"},    int'(bus.phase),        0);
        check({name, "_locked"},   int'(bus.locked),       0);
        check({name, "_misalign"}, int'(bus.misalign_cnt), 0);
    endtask

    function automatic void push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    // Lock acquired on strobe S: locked visible S+16, latches from S+17 to last, loss at fall.
    function automatic void push_lock(input int s, input int last, input int fall);
        push_ev(2, s + 16);
        for (int k = s + 17; k <= last; k++) begin
            if (((k - s) % 8) == 0)      push_ev(0, k);
            else if (((k - s) % 8) == 4) push_ev(1, k);
        end
        push_ev(3, fall);
    endfunction

    function automatic int ph2(input int j, input int s);
        return (((j - s + 1) % 8) >= 4) ? 1 : 0;
    endfunction

    task automatic match(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != kind) || (e.at != cyc)) begin
                failures++;
                $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                         kind, cyc, e.kind, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.latch0) match(0);
        if (bus.latch1) match(1);
        if (bus.locked != prev_locked) begin
            match(bus.locked ? 2 : 3);
            prev_locked = bus.locked;
        end
    end

    task automatic clk1(input logic s);
        bus.bx_strobe = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   s0, m, s1, x, s2, d, e, s3, r;
        int   md;
        logic s;

        bus.enable    = 1'b0;
        bus.bx_strobe = 1'b0;
        bus.mux_delay = 4'd3;
        bus.cnt_clear = 1'b0;
        md            = 3;

        #1 rst = 1'b1;
        #3 check_outputs("reset");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.enable = 1'b1;
        repeat (3) clk1(1'b0);

        // Lock, lose it on a dropped strobe, relock, lose it on a shifted train, then disable.
        s0 = cyc + 1;
        m  = s0 + 48;
        s1 = m + 4;
        x  = s1 + 24;
        s2 = x + 1;
        d  = s2 + 30;
        push_lock(s0, m, m);
        push_lock(s1, x, x);
        push_lock(s2, d - 1, d);

        for (int k = s0; k <= d + 10; k++) begin
            if (k < x) s = (((k - s0) % 4) == 0) && (k != m);
            else       s = (k > x) && (((k - s2) % 4) == 0);
            if (k == s0 + 20) md = 0;
            if (k == s0 + 24) md = 15;
            if (k == s0 + 32) md = 3;
            bus.mux_delay = 4'(md);
            bus.enable    = (k < d);
            clk1(s);

            if ((k >= s0 + 16) && (k < s0 + 32))
                check("mux_sel", int'(bus.mux_sel), ph2(k - 2 - md, s0));
            if (k == s0) check("acquire_phase", int'(bus.phase), 1);
            if (k == m - 1) check("cnt_before_miss", int'(bus.misalign_cnt), 0);
            if (k == m) begin
                check("miss_cnt", int'(bus.misalign_cnt), 1);
                check("miss_phase", int'(bus.phase), 0);
            end
            if (k == s1) check("reacquire_phase", int'(bus.phase), 1);
            if (k == x + 1) begin
                check("shift_phase", int'(bus.phase), 1);
                check("shift_cnt", int'(bus.misalign_cnt), 2);
            end
            if (k == d) begin
                check("disable_phase", int'(bus.phase), 0);
                check("disable_cnt", int'(bus.misalign_cnt), 2);
            end
            if (k == d + 10) check("disabled_cnt", int'(bus.misalign_cnt), 2);
        end

        // Continuous strobes: every cycle after acquisition is a wrong-phase event.
        e          = cyc + 1;
        bus.enable = 1'b1;
        for (int n = 0; n <= 322; n++) begin
            bus.cnt_clear = (n == 321);
            clk1(1'b1);
            if (n == 101) check("cnt_count", int'(bus.misalign_cnt), 102);
            if (n == 320) check("cnt_saturate", int'(bus.misalign_cnt), 255);
            if (n == 321) check("cnt_clear_prio", int'(bus.misalign_cnt), 0);
            if (n == 322) check("cnt_after_clear", int'(bus.misalign_cnt), 1);
        end
        bus.cnt_clear = 1'b0;
        repeat (10) clk1(1'b0);

        // Lock once more and hit it with an asynchronous reset.
        s3 = cyc + 1;
        r  = s3 + 22;
        push_lock(s3, s3 + 21, r);
        for (int k = s3; k <= r; k++) clk1(((k - s3) % 4) == 0);
        #1 rst = 1'b1;
        #1 check_outputs("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) clk1(1'b0);
        check("restart_phase", int'(bus.phase), 0);
        check("restart_locked", int'(bus.locked), 0);
        check("restart_cnt", int'(bus.misalign_cnt), 0);
        check("events_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
